reg_dump_uart_tx: RTL and testbench
===================================

// Module: reg_dump_uart_tx
// PURPOSE
//  Read-side companion to the 8x8 register bank: on a start pulse, walks read
//  addresses 0..NUM_REGS-1 and serialises each register byte out a UART TX line
//  (8N1, LSB first), preceded by header byte 0xA5. Uses one bank read port
//  (ra/rd, combinational read); lets a PC/terminal capture CPU state on the board.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); must be >= 2
//  NUM_REGS      8    registers dumped, addresses 0..NUM_REGS-1
//  ADDR_W        5    width of ra, matches bank read-address width
// PORTS
//  clk    in   1       rising-edge clock
//  rst    in   1       synchronous reset, active-high
//  start  in   1       request a dump; sampled only in IDLE
//  ra     out  ADDR_W  read address to register bank = idx counter
//  rd     in   8       read data from bank (combinational from ra)
//  tx     out  1       UART serial out, idles high
//  busy   out  1       1 while state != IDLE
//  done   out  1       one-cycle pulse after final stop bit of a dump
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, tx=1, busy=0, done=0, idx=0 (ra=0),
//   baud_cnt=0, bit_cnt=0, shift=0. Reset wins over every other event,
//   including mid-frame: tx returns high next cycle, no done pulse.
//  Outputs tx, busy, done registered or decoded from registered state only.
//  FSM: IDLE, START, DATA, STOP, FETCH.
//  - IDLE: tx=1. start=1 at edge -> shift<=8'hA5, idx<=0, baud_cnt<=0, ->START.
//    tx falls the cycle after start is sampled. done=0 except as below.
//  - START: tx=0 for CLKS_PER_BIT cycles, then bit_cnt<=0, ->DATA.
//  - DATA: tx=shift[0]; every CLKS_PER_BIT cycles shift>>=1, bit_cnt++;
//    after 8th bit ->STOP.
//  - STOP: tx=1 for CLKS_PER_BIT cycles; then idx==NUM_REGS -> done<=1, ->IDLE;
//    else ->FETCH.
//  - FETCH: exactly 1 cycle, tx=1, ra=idx; at edge shift<=rd, idx<=idx+1, ->START.
//  baud_cnt counts 0..CLKS_PER_BIT-1, cleared on every state change.
//  Byte order: 0xA5, reg[0], reg[1], ..., reg[NUM_REGS-1].
//  Per byte: 10*CLKS_PER_BIT cycles; FETCH adds 1 idle-high cycle between
//  register bytes (not between header and reg[0]'s START? no: FETCH precedes
//  every register byte, including reg[0]). busy cycles per dump =
//  (NUM_REGS+1)*10*CLKS_PER_BIT + NUM_REGS.
//  No snapshot: each register is read in its own FETCH cycle; a bank write
//  committed before that edge is reflected in the dump.
//  start while busy: ignored, not queued. start held high: new dump begins at
//  the edge after done (first IDLE cycle samples start).
//  idx width = ADDR_W+1 bits so idx==NUM_REGS is representable; ra=idx[ADDR_W-1:0].
//  done: high exactly one cycle (first IDLE cycle after last STOP), busy=0 then.
// TESTING (CLKS_PER_BIT=4, NUM_REGS=8; bench models bank + UART RX checker)
//  1 rst=1 two cycles -> tx=1, busy=0, done=0, ra=0; hold 20 cycles, tx stays 1.
//  2 bank = 00,11,22,...,77; 1-cycle start -> RX decodes A5,00,11,22,33,44,55,
//    66,77; busy high exactly 9*40+8=368 cycles; done one pulse, then busy=0.
//  3 reg[1]=0x5A -> its frame: low 4, bits 0,1,0,1,1,0,1,0 (4 cycles each),
//    high 4; ra=1 during the FETCH cycle preceding it.
//  4 start pulsed again at cycles 10 and 200 of dump -> still exactly 9 bytes,
//    one done; start held high -> second dump's tx falls 1 cycle after done.
//  5 rst=1 during DATA of reg[2] byte -> next cycle tx=1, busy=0, done never
//    pulses; new start -> full 9-byte dump beginning with A5.
//  6 write reg[5]=0xC3 while reg[2] byte in flight -> dumped reg[5] = C3.

Source files
------------

// File: rtl/reg_dump_uart_tx_if.sv
// ---------------------------------------------------------------------------
// reg_dump_uart_tx_if
//   Signal bundle for the register-dump UART transmitter.
//   start : request a dump (sampled only while the transmitter is idle)
//   ra    : read address presented to the register bank
//   rd    : byte returned by the bank, combinational from ra
//   tx    : UART serial line (8N1, LSB first), idles high
//   busy  : transmitter is walking the bank
//   done  : one-cycle pulse after the final stop bit of a dump
//   Modports: slave = transmitter view, master = controller/bank view.
// ---------------------------------------------------------------------------
interface reg_dump_uart_tx_if #(
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic [ADDR_W-1:0] ra;
  logic [7:0]        rd;
  logic              tx;
  logic              busy;
  logic              done;

  modport slave (
    input  start,
    input  rd,
    output ra,
    output tx,
    output busy,
    output done
  );

  modport master (
    output start,
    output rd,
    input  ra,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/reg_dump_uart_tx.sv
// ---------------------------------------------------------------------------
// reg_dump_uart_tx
//   On a start request, sends header byte 0xA5 followed by registers
//   0..NUM_REGS-1 out of a UART TX line (8N1, LSB first). Each register is
//   read through a single combinational bank read port in its own FETCH
//   cycle, so writes committed before that cycle appear in the dump.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : slave modport of reg_dump_uart_tx_if (start, ra, rd, tx, busy, done)
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit, must be >= 2
//   NUM_REGS     : number of registers dumped
//   ADDR_W       : bank read-address width
// ---------------------------------------------------------------------------
module reg_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 8,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  reg_dump_uart_tx_if.slave bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // One extra bit so the "all registers sent" value NUM_REGS is representable.
  localparam int IDX_W  = ADDR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(NUM_REGS);
  localparam logic [7:0]        HEADER    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_FETCH
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [IDX_W-1:0]    r_idx;
  logic                r_done;

  state_t              w_state_nx;
  logic [BAUD_W-1:0]   w_baud_nx;
  logic [2:0]          w_bit_nx;
  logic [7:0]          w_shift_nx;
  logic [IDX_W-1:0]    w_idx_nx;
  logic                w_done_nx;
  logic                w_baud_end;
  logic                w_tx;

  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_baud_cnt <= w_baud_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_idx      <= w_idx_nx;
      r_done     <= w_done_nx;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud_cnt;
    w_bit_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    w_idx_nx   = r_idx;
    w_done_nx  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_shift_nx = HEADER;
          w_idx_nx   = '0;
          w_baud_nx  = '0;
          w_state_nx = S_START;
        end
      end

      S_START: begin
        if (w_baud_end) begin
          w_baud_nx  = '0;
          w_bit_nx   = '0;
          w_state_nx = S_DATA;
        end else begin
          w_baud_nx = r_baud_cnt + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nx  = '0;
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_bit_nx   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nx = S_STOP;
          end
        end else begin
          w_baud_nx = r_baud_cnt + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nx = '0;
          if (r_idx == IDX_END) begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_FETCH;
          end
        end else begin
          w_baud_nx = r_baud_cnt + BAUD_W'(1);
        end
      end

      S_FETCH: begin
        // ra already carries idx; the bank answers combinationally this cycle.
        w_shift_nx = bus.rd;
        w_idx_nx   = r_idx + IDX_W'(1);
        w_baud_nx  = '0;
        w_state_nx = S_START;
      end

      default: begin
        w_state_nx = S_IDLE;
        w_baud_nx  = '0;
      end
    endcase
  end

  // Line level decoded purely from registered state
  always_comb begin
    w_tx = 1'b1;
    unique case (r_state)
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = r_shift[0];
      default: w_tx = 1'b1;
    endcase
  end

  assign bus.tx   = w_tx;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.ra   = r_idx[ADDR_W-1:0];

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
module tb_reg_dump_uart_tx;

  localparam int C      = 4;
  localparam int N      = 8;
  localparam int AW     = 5;
  localparam int FRAME  = 10 * C;
  localparam int TOTAL  = (N + 1) * FRAME + N;   // 368 busy cycles per dump

  logic clk;
  logic rst;
  logic [7:0] bank [32];

  reg_dump_uart_tx_if #(.ADDR_W(AW)) ifc ();

  reg_dump_uart_tx #(
    .CLKS_PER_BIT(C),
    .NUM_REGS    (N),
    .ADDR_W      (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  assign ifc.rd = bank[ifc.ra];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // The dump is a fixed timeline: header frame, then per register one
  // fetch cycle followed by a 10-bit frame. Expected outputs come from the
  // position within that timeline.
  logic [7:0] m_cap [N];

  initial begin : model
    bit   m_valid;
    bit   m_busy;
    bit   m_done;
    int   m_t;
    int   m_ra;
    int   u, k, r, pos, bitn;
    logic [7:0] byt;
    logic e_tx;
    int   e_ra;
    m_valid = 0; m_busy = 0; m_done = 0; m_t = 0; m_ra = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1; m_busy = 0; m_done = 0; m_ra = 0;
      end else if (m_valid) begin
        m_done = 0;
        if (m_busy) begin
          if (m_t >= FRAME && ((m_t - FRAME) % (FRAME + 1)) == 0)
            m_cap[(m_t - FRAME) / (FRAME + 1)] = bank[(m_t - FRAME) / (FRAME + 1)];
          m_t++;
          if (m_t == TOTAL) begin
            m_busy = 0; m_done = 1; m_ra = N;
          end
        end else if (ifc.start) begin
          m_busy = 1; m_t = 0;
        end
      end
      @(negedge clk);
      if (m_valid) begin
        if (!m_busy) begin
          e_tx = 1'b1;
          e_ra = m_ra;
        end else begin
          byt = 8'h00; pos = 0; e_tx = 1'b1;
          if (m_t < FRAME) begin
            byt = 8'hA5; pos = m_t; e_ra = 0;
          end else begin
            u = m_t - FRAME; k = u / (FRAME + 1); r = u % (FRAME + 1);
            if (r == 0) begin
              e_ra = k; pos = -1;
            end else begin
              byt = m_cap[k]; pos = r - 1; e_ra = k + 1;
            end
          end
          if (pos >= 0) begin
            bitn = pos / C;
            if (bitn == 0)      e_tx = 1'b0;
            else if (bitn == 9) e_tx = 1'b1;
            else                e_tx = byt[bitn-1];
          end
        end
        check("tx",   {31'd0, ifc.tx},   {31'd0, e_tx});
        check("busy", {31'd0, ifc.busy}, {31'd0, m_busy});
        check("done", {31'd0, ifc.done}, {31'd0, m_done});
        check("ra",   {27'd0, ifc.ra},   e_ra[31:0]);
      end
    end
  end

  // ---------------- UART receiver and activity monitor ----------------
  logic [7:0] rx_bytes [128];
  int rx_n = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  initial begin : rx
    bit   infr;
    int   cnt, b;
    logic prev;
    logic [7:0] sh;
    infr = 0; cnt = 0; prev = 1'b1; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (ifc.busy === 1'b1) busy_cycles++;
      if (ifc.done === 1'b1) done_pulses++;
      if (rst) begin
        infr = 0;
      end else if (!infr) begin
        if (prev === 1'b1 && ifc.tx === 1'b0) begin
          infr = 1; cnt = 0;
        end
      end else begin
        cnt++;
      end
      if (infr && !rst && (cnt % C) == C / 2) begin
        b = cnt / C;
        if (b >= 1 && b <= 8) sh[b-1] = ifc.tx;
        if (b == 9) begin
          check("rx_stop", {31'd0, ifc.tx}, 32'd1);
          if (rx_n < 128) rx_bytes[rx_n] = sh;
          rx_n++;
          infr = 0;
        end
      end
      prev = ifc.tx;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ifc.done !== 1'b1 && k < budget);
    if (ifc.done !== 1'b1) check("wait_done", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_dump [9];
  logic [9:0] frame_5a;
  int b_rx, b_busy, b_done;

  initial begin : main
    for (int i = 0; i < 32; i++) bank[i] = 8'h00;
    ifc.start = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // 1: reset state, line stays idle
    @(negedge clk);
    check("rst_tx",   {31'd0, ifc.tx},   32'd1);
    check("rst_busy", {31'd0, ifc.busy}, 32'd0);
    check("rst_done", {31'd0, ifc.done}, 32'd0);
    check("rst_ra",   {27'd0, ifc.ra},   32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx", {31'd0, ifc.tx}, 32'd1);
    end

    // 2: full dump of 00,11,..,77
    for (int i = 0; i < N; i++) bank[i] = 8'(i * 17);
    exp_dump = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    b_rx = rx_n; b_busy = busy_cycles; b_done = done_pulses;
    pulse_start();
    wait_done(600);
    step(); step();
    check("t2_busy_cycles", busy_cycles - b_busy, 32'd368);
    check("t2_done_pulses", done_pulses - b_done, 32'd1);
    check("t2_rx_count",    rx_n - b_rx,          32'd9);
    for (int i = 0; i < 9; i++)
      check("t2_rx_byte", {24'd0, rx_bytes[b_rx + i]}, {24'd0, exp_dump[i]});

    // 3: reg[1]=5A frame shape, ra=1 in the preceding fetch cycle
    bank[1] = 8'h5A;
    frame_5a = 10'b1010110100;   // index 0 = start bit ... index 9 = stop bit
    b_rx = rx_n;
    pulse_start();
    repeat (FRAME + FRAME + 1 + 1) @(negedge clk);
    check("t3_fetch_ra", {27'd0, ifc.ra}, 32'd1);
    check("t3_fetch_tx", {31'd0, ifc.tx}, 32'd1);
    for (int j = 0; j < 10; j++)
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        check("t3_frame_bit", {31'd0, ifc.tx}, {31'd0, frame_5a[j]});
      end
    wait_done(600);
    step();
    check("t3_rx_5a", {24'd0, rx_bytes[b_rx + 2]}, 32'h5A);

    // 4: start pulses during a dump are ignored
    b_rx = rx_n; b_done = done_pulses;
    pulse_start();
    repeat (9) step();
    ifc.start = 1'b1; step(); ifc.start = 1'b0;
    repeat (189) step();
    ifc.start = 1'b1; step(); ifc.start = 1'b0;
    wait_done(600);
    step(); step();
    check("t4_rx_count",    rx_n - b_rx,          32'd9);
    check("t4_done_pulses", done_pulses - b_done, 32'd1);
    // start held high: next dump begins right after done
    ifc.start = 1'b1;
    wait_done(600);
    @(negedge clk);
    check("t4_restart_tx",   {31'd0, ifc.tx},   32'd0);
    check("t4_restart_busy", {31'd0, ifc.busy}, 32'd1);
    step();
    ifc.start = 1'b0;
    wait_done(600);
    step();

    // 5: reset during DATA of reg[2]
    b_done = done_pulses;
    pulse_start();
    repeat (135) @(negedge clk);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_tx_after_rst",   {31'd0, ifc.tx},   32'd1);
    check("t5_busy_after_rst", {31'd0, ifc.busy}, 32'd0);
    repeat (400) step();
    check("t5_no_done", done_pulses - b_done, 32'd0);
    b_rx = rx_n;
    pulse_start();
    wait_done(600);
    step();
    check("t5_rx_count", rx_n - b_rx,                32'd9);
    check("t5_rx_hdr",   {24'd0, rx_bytes[b_rx]},    32'hA5);

    // 6: write reg[5] while reg[2] byte is in flight
    b_rx = rx_n;
    pulse_start();
    repeat (140) @(negedge clk);
    step();
    bank[5] = 8'hC3;
    wait_done(600);
    step();
    check("t6_rx_count", rx_n - b_rx,                 32'd9);
    check("t6_rx_reg5",  {24'd0, rx_bytes[b_rx + 6]}, 32'hC3);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
